de_fwd_pipe_reg: RTL and testbench
==================================

// Module: de_fwd_pipe_reg
// PURPOSE
//  D->E pipeline register of the 5-stage MIPS core; the producing end of the forwarding/hazard protocol
//  that the decode stage consumes (transE{addr,data,Tnew}). Latches decoded instruction state each cycle,
//  inserts bubbles on decode stall, holds on execute-side stall, flushes on exception/eret, and publishes
//  the E-stage forwarding tuple with Tnew aged by one stage. Also keeps a bubble counter for perf debug.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC loaded on reset (bubble PC until first real instruction)
//  EXC_PC     32'h0000_4180  PC loaded on flush (exception entry)
//  TNEW_W     3              width of Tnew fields
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  reset          in   1   synchronous, active-low reset
//  stop_D         in   1   decode stall request (hazard); insert bubble into E
//  hold_E         in   1   execute-side stall (e.g. mult/div busy); E register keeps contents
//  flush          in   1   exception/eret flush; E becomes empty
//  ins_D          in   32  instruction word from decode
//  pc_D           in   32  PC of decode instruction
//  bd_D           in   1   decode instruction is in a branch delay slot
//  aregwrite_D    in   5   destination register (0 = no write)
//  tnew_D         in   3   cycles until result ready, counted from D
//  datatrans_D    in   32  value already known at D (PC+8 for jal, rd index for mfc0/mtc0)
//  rd1_D, rd2_D   in   32  forwarded operands
//  imm_D          in   32  extended immediate
//  ctrl_D         in   16  {ALUctrl[4:0],ALUs[4:0],MemWrite[3:0],MemtoReg,ALUimm}
//  exp_D          in   1   exception pending from F/D
//  exccode_D      in   5   exception code
//  eret_D         in   1   instruction is eret
//  ins_E,pc_E,bd_E,rd1_E,rd2_E,imm_E,ctrl_E,exp_E,exccode_E,eret_E  out  (widths as D)  registered copies
//  transEaddr     out  5   destination reg of E instruction (0 for bubble)
//  transEdata     out  32  registered datatrans; meaningful only when transETnew==0
//  transETnew     out  3   remaining cycles from E
//  valid_E        out  1   E holds a real (non-bubble) instruction
//  bubble_cnt     out  32  number of bubbles inserted since reset
// BEHAVIOUR
//  - Priority each posedge: reset(==0) > flush > hold_E > stop_D > load.
//  - Reset: all outputs 0 except pc_E=RESET_PC; bubble_cnt=0; valid_E=0.
//  - Flush: outputs 0, pc_E=EXC_PC, bd_E=0, valid_E=0; flush overrides hold_E and stop_D; no count.
//  - Hold: every register unchanged (including Tnew, no ageing); stop_D ignored; no count.
//  - Bubble (stop_D=1): ins/ctrl/addr/Tnew/exp/eret/imm/rd1/rd2 cleared, valid_E=0; pc_E<=pc_D and
//    bd_E<=bd_D kept so a later exception on the bubble reports the correct EPC/BD; bubble_cnt+1.
//  - Load: all fields <= D values; valid_E=1; transETnew <= (tnew_D==0)?0:tnew_D-1 (saturating);
//    transEaddr <= aregwrite_D; transEdata <= datatrans_D.
//  - Latency 1 cycle D->E; tuple outputs are pure register outputs (no comb path from D inputs).
//  - bubble_cnt wraps 32'hFFFF_FFFF -> 0 silently.
//  - Reset asserted mid-hold or mid-flush: reset wins same cycle.
// TESTING
//  1 reset=0 two cycles -> all out 0, pc_E=0x3000, valid_E=0; release, load addu $3 pc=0x3000 tnew_D=1 -> transEaddr=3,transETnew=0
//  2 load jal pc=0x3010 tnew_D=0 datatrans_D=0x3018 -> transEaddr=31,transETnew=0,transEdata=0x3018
//  3 stop_D=1 with pc_D=0x3020,bd_D=1 -> next cycle transEaddr=0,valid_E=0,pc_E=0x3020,bd_E=1,bubble_cnt=1
//  4 lw tnew_D=3 loaded, then hold_E=1 for 3 cycles with stop_D=1 -> transETnew stays 2, bubble_cnt unchanged
//  5 flush=1 together with hold_E=1 and stop_D=1 -> pc_E=0x4180, all else 0, valid_E=0
//  6 preload bubble_cnt path: 2^32 stop cycles (or forced) -> wraps to 0; reset=0 during hold -> clears

Source files
------------

// File: rtl/de_fwd_pipe_reg_if.sv
// D->E pipeline register bundle: decode-side fields and stall controls in,
// E-stage register copies and forwarding tuple out.
interface de_fwd_pipe_reg_if #(
    parameter int TNEW_W = 3
);
    logic              stop_D;
    logic              hold_E;
    logic              flush;
    logic [31:0]       ins_D;
    logic [31:0]       pc_D;
    logic              bd_D;
    logic [4:0]        aregwrite_D;
    logic [TNEW_W-1:0] tnew_D;
    logic [31:0]       datatrans_D;
    logic [31:0]       rd1_D;
    logic [31:0]       rd2_D;
    logic [31:0]       imm_D;
    logic [15:0]       ctrl_D;
    logic              exp_D;
    logic [4:0]        exccode_D;
    logic              eret_D;

    logic [31:0]       ins_E;
    logic [31:0]       pc_E;
    logic              bd_E;
    logic [31:0]       rd1_E;
    logic [31:0]       rd2_E;
    logic [31:0]       imm_E;
    logic [15:0]       ctrl_E;
    logic              exp_E;
    logic [4:0]        exccode_E;
    logic              eret_E;
    logic [4:0]        transEaddr;
    logic [31:0]       transEdata;
    logic [TNEW_W-1:0] transETnew;
    logic              valid_E;
    logic [31:0]       bubble_cnt;

    modport master (
        output stop_D, hold_E, flush, ins_D, pc_D, bd_D, aregwrite_D, tnew_D,
               datatrans_D, rd1_D, rd2_D, imm_D, ctrl_D, exp_D, exccode_D, eret_D,
        input  ins_E, pc_E, bd_E, rd1_E, rd2_E, imm_E, ctrl_E, exp_E, exccode_E,
               eret_E, transEaddr, transEdata, transETnew, valid_E, bubble_cnt
    );

    modport slave (
        input  stop_D, hold_E, flush, ins_D, pc_D, bd_D, aregwrite_D, tnew_D,
               datatrans_D, rd1_D, rd2_D, imm_D, ctrl_D, exp_D, exccode_D, eret_D,
        output ins_E, pc_E, bd_E, rd1_E, rd2_E, imm_E, ctrl_E, exp_E, exccode_E,
               eret_E, transEaddr, transEdata, transETnew, valid_E, bubble_cnt
    );
endinterface

// File: rtl/de_fwd_pipe_reg.sv
// D->E pipeline register of the MIPS core: latches decode state, inserts bubbles,
// holds on execute stall, flushes on exception/eret, publishes the aged E forwarding tuple.
module de_fwd_pipe_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter int          TNEW_W   = 3
) (
    input logic             clk,
    input logic             reset,
    de_fwd_pipe_reg_if.slave bus
);

    logic [TNEW_W-1:0] tnew_aged;

    // Tnew counts from D; one stage later it is one less, never below zero.
    assign tnew_aged = (bus.tnew_D == '0) ? '0 : bus.tnew_D - TNEW_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.ins_E      <= '0;
            bus.pc_E       <= RESET_PC;
            bus.bd_E       <= 1'b0;
            bus.rd1_E      <= '0;
            bus.rd2_E      <= '0;
            bus.imm_E      <= '0;
            bus.ctrl_E     <= '0;
            bus.exp_E      <= 1'b0;
            bus.exccode_E  <= '0;
            bus.eret_E     <= 1'b0;
            bus.transEaddr <= '0;
            bus.transEdata <= '0;
            bus.transETnew <= '0;
            bus.valid_E    <= 1'b0;
            bus.bubble_cnt <= '0;
        end else if (bus.flush) begin
            bus.ins_E      <= '0;
            bus.pc_E       <= EXC_PC;
            bus.bd_E       <= 1'b0;
            bus.rd1_E      <= '0;
            bus.rd2_E      <= '0;
            bus.imm_E      <= '0;
            bus.ctrl_E     <= '0;
            bus.exp_E      <= 1'b0;
            bus.exccode_E  <= '0;
            bus.eret_E     <= 1'b0;
            bus.transEaddr <= '0;
            bus.transEdata <= '0;
            bus.transETnew <= '0;
            bus.valid_E    <= 1'b0;
        end else if (bus.hold_E) begin
            // Execute stage busy: freeze everything, Tnew does not age.
        end else if (bus.stop_D) begin
            // Bubble keeps pc/bd so an exception raised on it reports the right EPC/BD.
            bus.ins_E      <= '0;
            bus.pc_E       <= bus.pc_D;
            bus.bd_E       <= bus.bd_D;
            bus.rd1_E      <= '0;
            bus.rd2_E      <= '0;
            bus.imm_E      <= '0;
            bus.ctrl_E     <= '0;
            bus.exp_E      <= 1'b0;
            bus.exccode_E  <= '0;
            bus.eret_E     <= 1'b0;
            bus.transEaddr <= '0;
            bus.transEdata <= '0;
            bus.transETnew <= '0;
            bus.valid_E    <= 1'b0;
            bus.bubble_cnt <= bus.bubble_cnt + 32'd1;
        end else begin
            bus.ins_E      <= bus.ins_D;
            bus.pc_E       <= bus.pc_D;
            bus.bd_E       <= bus.bd_D;
            bus.rd1_E      <= bus.rd1_D;
            bus.rd2_E      <= bus.rd2_D;
            bus.imm_E      <= bus.imm_D;
            bus.ctrl_E     <= bus.ctrl_D;
            bus.exp_E      <= bus.exp_D;
            bus.exccode_E  <= bus.exccode_D;
            bus.eret_E     <= bus.eret_D;
            bus.transEaddr <= bus.aregwrite_D;
            bus.transEdata <= bus.datatrans_D;
            bus.transETnew <= tnew_aged;
            bus.valid_E    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_de_fwd_pipe_reg.sv
// Scoreboard bench for de_fwd_pipe_reg: directed D-side vectors push hand-computed
// E-stage snapshots; a monitor pops and compares one snapshot per clock.
module tb_de_fwd_pipe_reg;

    logic clk;
    logic reset;

    de_fwd_pipe_reg_if #(.TNEW_W(3)) bus ();

    de_fwd_pipe_reg #(
        .RESET_PC(32'h0000_3000),
        .EXC_PC  (32'h0000_4180),
        .TNEW_W  (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic        exc;
        logic [4:0]  code;
        logic        eret;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [2:0]  tnew;
        logic        valid;
        logic [31:0] bcnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec    = 0;

    function automatic exp_t mk(logic [31:0] ins, logic [31:0] pc, logic bd, logic [31:0] rd1,
                                logic [31:0] rd2, logic [31:0] imm, logic [15:0] ctrl, logic exc,
                                logic [4:0] code, logic eret, logic [4:0] addr, logic [31:0] data,
                                logic [2:0] tnew, logic valid, logic [31:0] bcnt);
        exp_t e;
        e.ins = ins;   e.pc = pc;     e.bd = bd;     e.rd1 = rd1;   e.rd2 = rd2;
        e.imm = imm;   e.ctrl = ctrl; e.exc = exc;   e.code = code; e.eret = eret;
        e.addr = addr; e.data = data; e.tnew = tnew; e.valid = valid; e.bcnt = bcnt;
        return e;
    endfunction

    function automatic exp_t bub(logic [31:0] pc, logic bd, logic [31:0] bcnt);
        return mk(32'h0, pc, bd, 32'h0, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 1'b0,
                  5'd0, 32'h0, 3'd0, 1'b0, bcnt);
    endfunction

    task automatic chk(input string name, input int v, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL vec%0d %s: got %h expected %h", v, name, act, req);
        end
    endtask

    // Monitor: one snapshot is due per clock while the scoreboard holds entries.
    initial begin
        exp_t e;
        int   n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n++;
                chk("ins_E",      n, bus.ins_E,              e.ins);
                chk("pc_E",       n, bus.pc_E,               e.pc);
                chk("bd_E",       n, {31'h0, bus.bd_E},      {31'h0, e.bd});
                chk("rd1_E",      n, bus.rd1_E,              e.rd1);
                chk("rd2_E",      n, bus.rd2_E,              e.rd2);
                chk("imm_E",      n, bus.imm_E,              e.imm);
                chk("ctrl_E",     n, {16'h0, bus.ctrl_E},    {16'h0, e.ctrl});
                chk("exp_E",      n, {31'h0, bus.exp_E},     {31'h0, e.exc});
                chk("exccode_E",  n, {27'h0, bus.exccode_E}, {27'h0, e.code});
                chk("eret_E",     n, {31'h0, bus.eret_E},    {31'h0, e.eret});
                chk("transEaddr", n, {27'h0, bus.transEaddr}, {27'h0, e.addr});
                chk("transEdata", n, bus.transEdata,         e.data);
                chk("transETnew", n, {29'h0, bus.transETnew}, {29'h0, e.tnew});
                chk("valid_E",    n, {31'h0, bus.valid_E},   {31'h0, e.valid});
                chk("bubble_cnt", n, bus.bubble_cnt,         e.bcnt);
            end
        end
    end

    task automatic set_ctl(input logic rst_n, input logic fl, input logic hold, input logic stop);
        reset      = rst_n;
        bus.flush  = fl;
        bus.hold_E = hold;
        bus.stop_D = stop;
    endtask

    task automatic set_d(input logic [31:0] ins, input logic [31:0] pc, input logic bd,
                         input logic [4:0] areg, input logic [2:0] tnew, input logic [31:0] dt,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                         input logic [15:0] ctrl, input logic exc, input logic [4:0] code,
                         input logic eret);
        bus.ins_D = ins;   bus.pc_D = pc;     bus.bd_D = bd;   bus.aregwrite_D = areg;
        bus.tnew_D = tnew; bus.datatrans_D = dt; bus.rd1_D = rd1; bus.rd2_D = rd2;
        bus.imm_D = imm;   bus.ctrl_D = ctrl; bus.exp_D = exc; bus.exccode_D = code;
        bus.eret_D = eret;
    endtask

    // Queue the snapshot expected after the coming posedge, then move to the next negedge.
    task automatic issue(input exp_t e);
        sb_q.push_back(e);
        vec++;
        @(negedge clk);
    endtask

    initial begin
        exp_t lw_e;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        set_d(32'hDEAD_BEEF, 32'h1111, 1'b1, 5'd9, 3'd2, 32'h55, 32'h1, 32'h2, 32'h3,
              16'hFFFF, 1'b1, 5'd7, 1'b1);
        @(negedge clk);

        // Reset held two cycles with garbage on D
        issue(bub(32'h3000, 1'b0, 32'd0));
        issue(bub(32'h3000, 1'b0, 32'd0));

        // addu $3 with tnew_D=1 -> Tnew 0 in E
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        set_d(32'h0022_1821, 32'h3000, 1'b0, 5'd3, 3'd1, 32'h0, 32'h11, 32'h22, 32'h0,
              16'h0402, 1'b0, 5'd0, 1'b0);
        issue(mk(32'h0022_1821, 32'h3000, 1'b0, 32'h11, 32'h22, 32'h0, 16'h0402, 1'b0, 5'd0,
                 1'b0, 5'd3, 32'h0, 3'd0, 1'b1, 32'd0));

        // jal: link value known at D
        set_d(32'h0C00_0C00, 32'h3010, 1'b0, 5'd31, 3'd0, 32'h3018, 32'h0, 32'h0, 32'h0,
              16'h0000, 1'b0, 5'd0, 1'b0);
        issue(mk(32'h0C00_0C00, 32'h3010, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0,
                 1'b0, 5'd31, 32'h3018, 3'd0, 1'b1, 32'd0));

        // Decode stall in a delay slot: bubble keeps pc/bd
        set_ctl(1'b1, 1'b0, 1'b0, 1'b1);
        set_d(32'h8C88_0004, 32'h3020, 1'b1, 5'd8, 3'd3, 32'hAA, 32'h40, 32'h50, 32'h4,
              16'h0843, 1'b1, 5'd4, 1'b1);
        issue(bub(32'h3020, 1'b1, 32'd1));

        // lw with tnew_D=3 -> Tnew 2
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        set_d(32'h8C88_0004, 32'h3024, 1'b0, 5'd8, 3'd3, 32'hAA, 32'h40, 32'h50, 32'h4,
              16'h0843, 1'b0, 5'd0, 1'b0);
        lw_e = mk(32'h8C88_0004, 32'h3024, 1'b0, 32'h40, 32'h50, 32'h4, 16'h0843, 1'b0, 5'd0,
                  1'b0, 5'd8, 32'hAA, 3'd2, 1'b1, 32'd1);
        issue(lw_e);

        // Hold with stop_D asserted: nothing changes, no ageing, no count
        set_ctl(1'b1, 1'b0, 1'b1, 1'b1);
        set_d(32'h0123_4567, 32'h3028, 1'b1, 5'd9, 3'd1, 32'h77, 32'h9, 32'h8, 32'h7,
              16'h5555, 1'b1, 5'd3, 1'b1);
        for (int i = 0; i < 3; i++) issue(lw_e);

        // Flush beats hold and stop; counter untouched
        set_ctl(1'b1, 1'b1, 1'b1, 1'b1);
        issue(bub(32'h4180, 1'b0, 32'd1));

        // Exception-carrying instruction, tnew_D=0 saturates
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        set_d(32'h0000_000C, 32'h4180, 1'b1, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0,
              16'h0000, 1'b1, 5'd8, 1'b0);
        issue(mk(32'h0000_000C, 32'h4180, 1'b1, 32'h0, 32'h0, 32'h0, 16'h0, 1'b1, 5'd8,
                 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 32'd1));

        // Two back-to-back bubbles
        set_ctl(1'b1, 1'b0, 1'b0, 1'b1);
        set_d(32'h1111_2222, 32'h4184, 1'b0, 5'd5, 3'd2, 32'h9, 32'h9, 32'h9, 32'h9,
              16'h00F0, 1'b0, 5'd0, 1'b0);
        issue(bub(32'h4184, 1'b0, 32'd2));
        bus.pc_D = 32'h4188;
        issue(bub(32'h4188, 1'b0, 32'd3));

        // eret
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        set_d(32'h4200_0018, 32'h418C, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0,
              16'h0001, 1'b0, 5'd0, 1'b1);
        issue(mk(32'h4200_0018, 32'h418C, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0001, 1'b0, 5'd0,
                 1'b1, 5'd0, 32'h0, 3'd0, 1'b1, 32'd3));

        // Reset during hold, then during flush: reset wins and clears the counter
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
        issue(bub(32'h3000, 1'b0, 32'd0));
        set_ctl(1'b0, 1'b1, 1'b0, 1'b1);
        issue(bub(32'h3000, 1'b0, 32'd0));
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        issue(bub(32'h4180, 1'b0, 32'd0));

        // mtc0-style: value known at D, tnew_D=2 -> 1
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        set_d(32'h4080_6000, 32'h4180, 1'b0, 5'd0, 3'd2, 32'd12, 32'h0, 32'hCAFE, 32'h0,
              16'h0100, 1'b0, 5'd0, 1'b0);
        issue(mk(32'h4080_6000, 32'h4180, 1'b0, 32'h0, 32'hCAFE, 32'h0, 16'h0100, 1'b0, 5'd0,
                 1'b0, 5'd0, 32'd12, 3'd1, 1'b1, 32'd0));

        begin
            int budget;
            budget = 10;
            while (sb_q.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            checks++;
            if (sb_q.size() > 0) begin
                errors++;
                $display("FAIL drain: got %0d pending expected 0", sb_q.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
